// File: rtl/param_sync_fifo_if.sv
// Handshake and status bundle for param_sync_fifo.
// The master drives requests and write data. The slave (the FIFO) drives read data and flags.
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  FIFO_FLUSH;
  logic                  FIFO_CLR_ERR;
  logic                  FIFO_WR_EN;
  logic [DATA_WIDTH-1:0] FIFO_DATA_IN;
  logic                  FIFO_RD_EN;
  logic [DATA_WIDTH-1:0] FIFO_DATA_OUT;
  logic                  FIFO_DATA_VALID;
  logic                  FIFO_FULL;
  logic                  FIFO_EMPTY;
  logic                  FIFO_ALMOST_FULL;
  logic                  FIFO_ALMOST_EMPTY;
  logic [CW-1:0]         FIFO_COUNT;
  logic                  FIFO_OVERFLOW;
  logic                  FIFO_UNDERFLOW;

  modport master (
    output FIFO_FLUSH, FIFO_CLR_ERR, FIFO_WR_EN, FIFO_DATA_IN, FIFO_RD_EN,
    input  FIFO_DATA_OUT, FIFO_DATA_VALID, FIFO_FULL, FIFO_EMPTY,
           FIFO_ALMOST_FULL, FIFO_ALMOST_EMPTY, FIFO_COUNT,
           FIFO_OVERFLOW, FIFO_UNDERFLOW
  );

  modport slave (
    input  FIFO_FLUSH, FIFO_CLR_ERR, FIFO_WR_EN, FIFO_DATA_IN, FIFO_RD_EN,
    output FIFO_DATA_OUT, FIFO_DATA_VALID, FIFO_FULL, FIFO_EMPTY,
           FIFO_ALMOST_FULL, FIFO_ALMOST_EMPTY, FIFO_COUNT,
           FIFO_OVERFLOW, FIFO_UNDERFLOW
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with a registered read port (1-cycle read latency) and an explicit occupancy counter.
// A write is refused when the FIFO is full, unless a read is accepted in the same cycle. Refused requests set sticky error flags.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input logic              clk,
  input logic              reset,
  param_sync_fifo_if.slave fifo
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  vld_q, vld_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic rd_ok, wr_ok, rd_acc, wr_acc;

  // The full check is against the registered count. A read in the same cycle frees a slot.
  assign rd_ok  = fifo.FIFO_RD_EN && (count_q != '0);
  assign wr_ok  = fifo.FIFO_WR_EN && ((count_q != FULL_CNT) || rd_ok);
  assign rd_acc = rd_ok && !fifo.FIFO_FLUSH;
  assign wr_acc = wr_ok && !fifo.FIFO_FLUSH;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    vld_d    = 1'b0;
    ovf_d    = ovf_q && !fifo.FIFO_CLR_ERR;
    udf_d    = udf_q && !fifo.FIFO_CLR_ERR;

    if (fifo.FIFO_FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        dout_d   = mem_q[rd_ptr_q];
        vld_d    = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // A new error in the same cycle as a clear sets the flag again.
      if (fifo.FIFO_WR_EN && !wr_ok) begin
        ovf_d = 1'b1;
      end
      if (fifo.FIFO_RD_EN && !rd_ok) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage has no reset. The count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem_q[wr_ptr_q] <= fifo.FIFO_DATA_IN;
    end
  end

  assign fifo.FIFO_DATA_OUT     = dout_q;
  assign fifo.FIFO_DATA_VALID   = vld_q;
  assign fifo.FIFO_COUNT        = count_q;
  assign fifo.FIFO_FULL         = (count_q == FULL_CNT);
  assign fifo.FIFO_EMPTY        = (count_q == '0);
  assign fifo.FIFO_ALMOST_FULL  = (count_q >= AF_CNT);
  assign fifo.FIFO_ALMOST_EMPTY = (count_q <= AE_CNT);
  assign fifo.FIFO_OVERFLOW     = ovf_q;
  assign fifo.FIFO_UNDERFLOW    = udf_q;
endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data word width in bits (legal: 1 or more).
REQ-002 Parameter DEPTH, default 16, SHALL set the number of storage entries (legal: a power of 2, 4 or more).
REQ-003 Parameter AF_LEVEL, default DEPTH-2, SHALL set the almost-full threshold (legal: 1 to DEPTH-1).
REQ-004 Parameter AE_LEVEL, default 2, SHALL set the almost-empty threshold (legal: 1 to DEPTH-1).
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-007 FIFO_FLUSH  input  1  SHALL be the synchronous discard of all stored entries.
REQ-008 FIFO_CLR_ERR  input  1  SHALL clear the sticky error flags.
REQ-009 FIFO_WR_EN  input  1  SHALL be the write request.
REQ-010 FIFO_DATA_IN  input  DATA_WIDTH  SHALL be the write data.
REQ-011 FIFO_RD_EN  input  1  SHALL be the read request.
REQ-012 FIFO_DATA_OUT  output  DATA_WIDTH  SHALL be the registered read data.
REQ-013 FIFO_DATA_VALID  output  1  SHALL pulse high for one cycle when FIFO_DATA_OUT carries newly read data.
REQ-014 FIFO_FULL, FIFO_EMPTY, FIFO_ALMOST_FULL, FIFO_ALMOST_EMPTY  output  1 each  SHALL be the status flags.
REQ-015 FIFO_COUNT  output  $clog2(DEPTH+1)  SHALL be the current occupancy.
REQ-016 FIFO_OVERFLOW, FIFO_UNDERFLOW  output  1 each  SHALL be the sticky error flags.

Function
REQ-017 All DEPTH entries SHALL be usable: FIFO_FULL = (COUNT==DEPTH) and FIFO_EMPTY = (COUNT==0), both decoded combinationally from registered COUNT.
REQ-018 FIFO_ALMOST_FULL = (COUNT >= AF_LEVEL) and FIFO_ALMOST_EMPTY = (COUNT <= AE_LEVEL), both combinational from COUNT.
REQ-019 Read accept: rd_ok = FIFO_RD_EN and COUNT != 0.
REQ-020 Write accept: wr_ok = FIFO_WR_EN and (COUNT != DEPTH, or rd_ok in the same cycle); a full FIFO with a simultaneous accepted read SHALL also accept the write.
REQ-021 On wr_ok, FIFO_DATA_IN SHALL be written at the write pointer, and the write pointer SHALL increment modulo DEPTH.
REQ-022 On rd_ok, the entry at the read pointer SHALL be registered into FIFO_DATA_OUT at the same edge, giving 1-cycle latency. FIFO_DATA_VALID SHALL be 1 in the following cycle. The read pointer SHALL increment modulo DEPTH.
REQ-023 Without rd_ok, FIFO_DATA_OUT SHALL hold its last value and FIFO_DATA_VALID SHALL be 0.
REQ-024 COUNT update: +1 on wr_ok only; -1 on rd_ok only; unchanged on both or neither.
REQ-025 Simultaneous write and read when empty: only the write is accepted, COUNT becomes 1, no data is output, and FIFO_UNDERFLOW is set.
REQ-026 FIFO_OVERFLOW SHALL set on FIFO_WR_EN without wr_ok; FIFO_UNDERFLOW SHALL set on FIFO_RD_EN without rd_ok; both are sticky.
REQ-027 FIFO_CLR_ERR SHALL clear both error flags; if a new error occurs in the same cycle, the set SHALL win.
REQ-028 FIFO_FLUSH SHALL zero both pointers and COUNT and SHALL force FIFO_DATA_VALID to 0. It overrides FIFO_WR_EN and FIFO_RD_EN in that cycle: no error flags are set, no data is written, and FIFO_DATA_OUT holds. Memory contents are left unchanged.
REQ-029 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated entry.
REQ-030 Storage SHALL have no reset; stale memory SHALL never be visible, because every read is gated by COUNT.

Reset
REQ-031 While reset is high at a rising clk edge: pointers = 0, COUNT = 0, FIFO_DATA_OUT = 0, FIFO_DATA_VALID = 0, FIFO_OVERFLOW = 0, FIFO_UNDERFLOW = 0.
REQ-032 Reset SHALL take priority over FIFO_FLUSH, writes and reads.
REQ-033 After reset: FIFO_EMPTY = 1, FIFO_ALMOST_EMPTY = 1, FIFO_FULL = 0, FIFO_ALMOST_FULL = 0.
REQ-034 Reset asserted mid-operation SHALL discard all contents in one cycle; the first write after release SHALL be the first data read back.

Verification (defaults DATA_WIDTH=32, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-035 Fill/drain: write 0x00..0x0F on 16 cycles, then read 16 -> FULL after the 16th write; ALMOST_FULL from COUNT=14; data out 0x00..0x0F in order, each with VALID one cycle after RD_EN; EMPTY and COUNT=0 at the end.
REQ-036 Overflow/underflow: with the FIFO full, write 0xDEAD -> write rejected, OVERFLOW=1, COUNT=16. Drain, then read once more -> UNDERFLOW=1, DATA_OUT unchanged. Pulse FIFO_CLR_ERR -> both flags 0.
REQ-037 Full pass-through: with the FIFO full, assert WR_EN and RD_EN together with data 0xA5A5A5A5 -> both accepted, COUNT stays 16, no OVERFLOW; 0xA5A5A5A5 emerges as the 16th subsequent read.
REQ-038 Wrap: run 40 cycles of simultaneous write and read at COUNT=3 with an incrementing pattern -> COUNT constant at 3, no gaps or duplicates across 2+ pointer wraps.
REQ-039 Flush vs. reset: with COUNT=9, assert FIFO_FLUSH together with WR_EN and RD_EN -> COUNT=0, EMPTY=1, VALID=0, no error flags. Refill 5, then assert reset for 1 cycle -> all outputs at their REQ-031 values.
